// File: rtl/mbus_ahb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mf8_bus_pkg
// Description : Shared AHB encodings, bridge state type and default base
//               address for the MF8A18 memory-bus to AHB-Lite bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package mf8_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HSIZE_BYTE    = 2'b00;
  localparam logic [1:0] HSIZE_WORD    = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h2000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WDATA = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RDONE = 3'd5
  } bridge_state_t;

  // Little-endian byte lane select from a 32-bit word
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbus_ahb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mbus_if / ahb_if
// Description : CPU memory-bus and AHB-Lite signal bundles. In mbus_if the
//               CPU is master and the bridge is slave; in ahb_if the bridge
//               is master and the eSRAM port is slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface mbus_if;
  logic [15:0] maddr;
  logic [7:0]  mwdata;
  logic        mread;
  logic        mwrite;
  logic [7:0]  mrdata;
  logic        mready;

  modport master (output maddr, mwdata, mread, mwrite, input mrdata, mready);
  modport slave  (input maddr, mwdata, mread, mwrite, output mrdata, mready);
endinterface

interface ahb_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [1:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (output HADDR, HTRANS, HSIZE, HWRITE, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave  (input HADDR, HTRANS, HSIZE, HWRITE, HWDATA, output HRDATA, HREADY, HRESP);
endinterface
`default_nettype wire

// File: rtl/mbus_ahb_bridge_word_buf.sv
`default_nettype none
// ============================================================================
// Module      : mbus_word_buf
// Description : One-entry word read buffer (valid/tag/data) with tag lookup,
//               whole-word fill, single-byte update and invalidate.
// Revision    : 1.0 - initial release
// ============================================================================
module mbus_word_buf #(
  parameter int TAG_BITS = 13
) (
  input  wire logic                clk,
  input  wire logic                resetn,
  input  wire logic [TAG_BITS-1:0] lookup_tag,
  output logic                     hit,
  output logic [31:0]              data,
  input  wire logic                fill_en,
  input  wire logic [TAG_BITS-1:0] fill_tag,
  input  wire logic [31:0]         fill_data,
  input  wire logic                upd_en,
  input  wire logic [1:0]          upd_sel,
  input  wire logic [7:0]          upd_byte,
  input  wire logic                inv_en
);

  logic                r_valid;
  logic [TAG_BITS-1:0] r_tag;
  logic [31:0]         r_data;

  // Buffer state; invalidate outranks fill, fill outranks byte update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (inv_en) begin
      r_valid <= 1'b0;
    end else if (fill_en) begin
      r_valid <= 1'b1;
      r_tag   <= fill_tag;
      r_data  <= fill_data;
    end else if (upd_en) begin
      r_data[{upd_sel, 3'b000} +: 8] <= upd_byte;
    end
  end

  assign hit  = r_valid && (r_tag == lookup_tag);
  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/mbus_ahb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mbus_ahb_bridge
// Description : MF8A18 8-bit memory bus to 32-bit AHB-Lite master. Posted
//               byte writes, word reads through a one-entry read buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mbus_ahb_bridge
  import mf8_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          ADDR_BITS = 15
) (
  input  wire logic clk,
  input  wire logic resetn,
  mbus_if.slave     mbus,
  ahb_if.master     ahb,
  output logic      bus_err
);

  localparam int TAG_BITS = ADDR_BITS - 2;

  bridge_state_t        r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_mready;
  logic [7:0]           r_mrdata;
  logic [31:0]          r_hwdata;
  logic                 r_bus_err;

  logic [ADDR_BITS-1:0] w_req_addr;
  logic [TAG_BITS-1:0]  w_req_tag;
  logic                 w_idle_req;
  logic                 w_hit;
  logic [31:0]          w_buf_data;
  logic                 w_fill_en;
  logic                 w_upd_en;
  logic                 w_inv_en;
  logic [1:0]           w_htrans;
  logic [1:0]           w_hsize;
  logic                 w_hwrite;
  logic [ADDR_BITS-1:0] w_off;

  assign w_req_addr = mbus.maddr[ADDR_BITS-1:0];
  assign w_req_tag  = w_req_addr[ADDR_BITS-1:2];
  // A request is only considered in IDLE and never in the mready cycle
  assign w_idle_req = (r_state == ST_IDLE) && !r_mready;

  generate
    if (ADDR_BITS < 16) begin : g_unused_hi
      logic w_unused_maddr;
      assign w_unused_maddr = ^mbus.maddr[15:ADDR_BITS];
    end
  endgenerate

  assign w_fill_en = (r_state == ST_RDATA) && ahb.HREADY && !ahb.HRESP;
  assign w_upd_en  = w_idle_req && mbus.mwrite && w_hit;
  assign w_inv_en  = ((r_state == ST_RDATA) || (r_state == ST_WDATA)) && ahb.HREADY && ahb.HRESP;

  mbus_word_buf #(.TAG_BITS(TAG_BITS)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_tag (w_req_tag),
    .hit        (w_hit),
    .data       (w_buf_data),
    .fill_en    (w_fill_en),
    .fill_tag   (r_addr[ADDR_BITS-1:2]),
    .fill_data  (ahb.HRDATA),
    .upd_en     (w_upd_en),
    .upd_sel    (w_req_addr[1:0]),
    .upd_byte   (mbus.mwdata),
    .inv_en     (w_inv_en)
  );

  // Bridge sequencer with registered CPU-side outputs and write data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_mready  <= 1'b0;
      r_mrdata  <= 8'h00;
      r_hwdata  <= 32'h0;
      r_bus_err <= 1'b0;
    end else begin
      r_mready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_mready) begin
            if (mbus.mwrite) begin
              r_addr   <= w_req_addr;
              r_hwdata <= {4{mbus.mwdata}};
              r_mready <= 1'b1;
              r_state  <= ST_WADDR;
            end else if (mbus.mread) begin
              if (w_hit) begin
                r_mrdata <= sel_byte(w_buf_data, w_req_addr[1:0]);
                r_mready <= 1'b1;
              end else begin
                r_addr  <= w_req_addr;
                r_state <= ST_RADDR;
              end
            end
          end
        end
        ST_WADDR: if (ahb.HREADY) r_state <= ST_WDATA;
        ST_WDATA: begin
          if (ahb.HREADY) begin
            if (ahb.HRESP) r_bus_err <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RADDR: if (ahb.HREADY) r_state <= ST_RDATA;
        ST_RDATA: begin
          if (ahb.HREADY) begin
            r_mready <= 1'b1;
            r_mrdata <= ahb.HRESP ? 8'hFF : sel_byte(ahb.HRDATA, r_addr[1:0]);
            if (ahb.HRESP) r_bus_err <= 1'b1;
            r_state  <= ST_RDONE;
          end
        end
        ST_RDONE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // AHB address-phase controls decoded from the state register only
  always_comb begin
    w_htrans = HTRANS_IDLE;
    w_hsize  = HSIZE_BYTE;
    w_hwrite = 1'b0;
    w_off    = r_addr;
    case (r_state)
      ST_WADDR: begin
        w_htrans = HTRANS_NONSEQ;
        w_hwrite = 1'b1;
      end
      ST_RADDR: begin
        w_htrans = HTRANS_NONSEQ;
        w_hsize  = HSIZE_WORD;
        w_off    = {r_addr[ADDR_BITS-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign ahb.HTRANS = w_htrans;
  assign ahb.HSIZE  = w_hsize;
  assign ahb.HWRITE = w_hwrite;
  assign ahb.HADDR  = BASE_ADDR + 32'(w_off);
  assign ahb.HWDATA = r_hwdata;
  assign mbus.mready = r_mready;
  assign mbus.mrdata = r_mrdata;
  assign bus_err     = r_bus_err;

endmodule
`default_nettype wire
